inst_capture: RTL and testbench

INST_CAPTURE -- requirements
Module: inst_capture

---
 rtl/inst_capture.sv | 171 +++++++++++++++++
 tb/tb_inst_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_capture.sv
// Debounced execute-button instruction capture: synchronizes btn_in/sw, debounces the button
// and latches the switch word with a one-cycle inst_vld pulse. Define INST_REPEAT_EN for auto-repeat.
module inst_capture #(
   parameter int DB_CYCLES     = 50000,
   parameter int REPEAT_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_in,
   input  logic [7:0] sw,
   output logic       inst_vld,
   output logic [7:0] inst_wd,
   output logic       db_level
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int            CW      = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_MAX  = CW'(DB_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [1:0]      btn_sync_q;
   logic [7:0]      sw_meta_q;
   logic [7:0]      sw_sync_q;
   logic            btn_s;
   logic [7:0]      sw_s;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   cnt_inc;
   logic            cnt_done;
   logic            capture;
   logic            rep_fire;
   logic            inst_vld_q, inst_vld_d;
   logic [7:0]      inst_wd_q, inst_wd_d;

   // Two-flop synchronizers; nothing downstream touches the raw pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_sync_q <= 2'b00;
         sw_meta_q  <= 8'h00;
         sw_sync_q  <= 8'h00;
      end else begin
         btn_sync_q <= {btn_sync_q[0], btn_in};
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
      end
   end

   assign btn_s = btn_sync_q[1];
   assign sw_s  = sw_sync_q;

   assign cnt_inc  = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_ONE;
   assign cnt_done = (cnt_inc == DB_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = HELD;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         RELEASE_WAIT: begin
            // A return to HELD here is release bounce and never produces a pulse.
            if (btn_s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef INST_REPEAT_EN
   localparam int             RW_W     = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW_W-1:0] REP_LAST = RW_W'(REPEAT_CYCLES - 1);
   localparam logic [RW_W-1:0] REP_ONE  = RW_W'(1);

   logic [RW_W-1:0] rep_q, rep_d;

   // Counter only advances while HELD with the button down, so release bounces freeze it.
   always_comb begin
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (capture) begin
         rep_d = '0;
      end else if ((state_q == HELD) && btn_s) begin
         if (rep_q >= REP_LAST) begin
            rep_fire = 1'b1;
            rep_d    = '0;
         end else begin
            rep_d = rep_q + REP_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end
`else
   assign rep_fire = 1'b0;

   if (REPEAT_CYCLES < 1) begin : g_repeat_cfg_unused
   end
`endif

   assign inst_vld_d = capture | rep_fire;
   assign inst_wd_d  = inst_vld_d ? sw_s : inst_wd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         inst_vld_q <= 1'b0;
         inst_wd_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inst_vld_q <= inst_vld_d;
         inst_wd_q  <= inst_wd_d;
      end
   end

   assign inst_vld = inst_vld_q;
   assign inst_wd  = inst_wd_q;
   assign db_level = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_inst_capture.sv
// Directed bench for inst_capture: expected pulses (cycle + word) are queued when the button
// is driven and matched by a negedge monitor; level checks are inline assertions.
module tb_inst_capture;

   localparam int DB = 4;
   localparam int RP = 8;
`ifdef INST_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_in;
   logic [7:0] sw;
   logic       inst_vld;
   logic [7:0] inst_wd;
   logic       db_level;

   inst_capture #(.DB_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .sw       (sw),
      .inst_vld (inst_vld),
      .inst_wd  (inst_wd),
      .db_level (db_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   int         exp_cyc_q[$];
   logic [7:0] exp_wd_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Button driven high at the negedge where cyc==c0 is first sampled at relative edge 0;
   // a pulse registered at relative edge e is seen by the monitor with cyc == c0+1+e.
   task automatic push_pulses(input int c0, input int hold, input logic [7:0] wd);
      int e;
      e = DB + 1;
      while (e <= hold + 1) begin
         exp_cyc_q.push_back(c0 + 1 + e);
         exp_wd_q.push_back(wd);
         if (!REP) break;
         e += RP;
      end
   endtask

   always @(negedge clk) begin
      if (inst_vld === 1'b1) begin
         if (exp_cyc_q.size() == 0) begin
            check("unexpected_pulse_queue", exp_cyc_q.size(), 1);
         end else begin
            int         ec;
            logic [7:0] ew;
            ec = exp_cyc_q.pop_front();
            ew = exp_wd_q.pop_front();
            $display("pulse at cycle %0d inst_wd=0x%02h (expected cycle %0d word 0x%02h)", cyc, inst_wd, ec, ew);
            check("pulse_cycle", cyc, ec);
            check("pulse_wd", {24'h0, inst_wd}, {24'h0, ew});
         end
      end
   end

   initial begin
      int c0;
      rst_n  = 1'b0;
      btn_in = 1'b0;
      sw     = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_vld", {31'h0, inst_vld}, 0);
      check("reset_wd", {24'h0, inst_wd}, 0);
      check("reset_db", {31'h0, db_level}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic capture: 20-cycle press with sw=0x14
      sw = 8'h14;
      repeat (3) @(negedge clk);
      c0 = cyc;
      push_pulses(c0, 20, 8'h14);
      btn_in = 1'b1;
      repeat (10) @(negedge clk);
      check("t1_db_held", {31'h0, db_level}, 1);
      check("t1_wd_held", {24'h0, inst_wd}, 32'h14);
      repeat (10) @(negedge clk);
      btn_in = 1'b0;
      repeat (5) @(negedge clk);
      check("t1_db_release3", {31'h0, db_level}, 1);
      @(negedge clk);
      check("t1_db_idle", {31'h0, db_level}, 0);

      // Short glitch: 3 cycles high is rejected
      c0 = cyc;
      push_pulses(c0, 3, 8'h14);
      btn_in = 1'b1;
      repeat (3) @(negedge clk);
      check("t2_db_presswait", {31'h0, db_level}, 0);
      btn_in = 1'b0;
      repeat (8) @(negedge clk);
      check("t2_db", {31'h0, db_level}, 0);
      check("t2_wd", {24'h0, inst_wd}, 32'h14);

      // Switch changes after capture and during release are ignored
      c0 = cyc;
      push_pulses(c0, 10, 8'h14);
      btn_in = 1'b1;
      repeat (8) @(negedge clk);
      sw = 8'hC0;
      repeat (2) @(negedge clk);
      btn_in = 1'b0;
      repeat (8) @(negedge clk);
      check("t3_wd", {24'h0, inst_wd}, 32'h14);
      check("t3_db", {31'h0, db_level}, 0);

      // Release bounce: low 2, high 10, low 6
      sw = 8'h5A;
      repeat (3) @(negedge clk);
      c0 = cyc;
      push_pulses(c0, 8, 8'h5A);
      if (REP) begin
         exp_cyc_q.push_back(c0 + 17);
         exp_wd_q.push_back(8'h5A);
      end
      btn_in = 1'b1;
      repeat (8) @(negedge clk);
      btn_in = 1'b0;
      repeat (2) @(negedge clk);
      btn_in = 1'b1;
      repeat (2) @(negedge clk);
      check("t4_db_bounce", {31'h0, db_level}, 1);
      repeat (8) @(negedge clk);
      btn_in = 1'b0;
      repeat (5) @(negedge clk);
      check("t4_db_release3", {31'h0, db_level}, 1);
      @(negedge clk);
      check("t4_db_idle", {31'h0, db_level}, 0);

      // Reset mid-PRESS_WAIT (count=2)
      sw = 8'h77;
      repeat (3) @(negedge clk);
      btn_in = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_rst_vld", {31'h0, inst_vld}, 0);
      check("t5_rst_wd", {24'h0, inst_wd}, 0);
      check("t5_rst_db", {31'h0, db_level}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      btn_in = 1'b0;
      repeat (8) @(negedge clk);
      check("t5_wd_after", {24'h0, inst_wd}, 0);
      check("t5_db_after", {31'h0, db_level}, 0);

      // Long 30-cycle hold (auto-repeat when enabled)
      sw = 8'h3C;
      repeat (3) @(negedge clk);
      c0 = cyc;
      push_pulses(c0, 30, 8'h3C);
      btn_in = 1'b1;
      repeat (30) @(negedge clk);
      btn_in = 1'b0;
      repeat (10) @(negedge clk);
      check("t6_db_idle", {31'h0, db_level}, 0);
      check("t6_vld_low", {31'h0, inst_vld}, 0);
      check("t6_wd", {24'h0, inst_wd}, 32'h3C);
      check("pending_pulses", exp_cyc_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
